// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline: writeback result select, exception codes
// and the memory-stage access state machine states.
package riscv_pkg;
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

    typedef logic [1:0] mstate_t;
    localparam mstate_t ST_IDLE = 2'd0;
    localparam mstate_t ST_REQ  = 2'd1;
    localparam mstate_t ST_WAIT = 2'd2;
endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory bus sequencer for the M stage: request handshake, response wait with
// timeout, and the pipeline stall derived from the access state.
module mem_access_fsm
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic req_ready,
    input  logic rsp_valid,
    output logic req_valid,
    output logic stall,
    output logic done,
    output logic abort
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    mstate_t    state;
    mstate_t    state_next;
    logic [7:0] wait_cnt;
    logic       in_wait;

    assign in_wait = (state == ST_WAIT);
    // A response arriving in the same cycle as the limit takes priority over the abort.
    assign done    = in_wait && rsp_valid;
    assign abort   = in_wait && !rsp_valid && (wait_cnt == LIMIT);

    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        stall      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    req_valid  = 1'b1;
                    stall      = 1'b1;
                    state_next = req_ready ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                stall     = 1'b1;
                if (req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done || abort) begin
                    state_next = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (rst) begin
            req_valid = 1'b0;
            stall     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_next;
            // Held at zero outside WAIT so every access starts its wait from a clean count.
            if (!in_wait) begin
                wait_cnt <= 8'd0;
            end else if (!rsp_valid) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/memory_cycle.sv
// RV32I memory stage: issues word loads/stores on the data-memory bus, stalls upstream
// while an access is outstanding, and owns the M/W pipeline register.
module memory_cycle
    import riscv_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [4:0]        RD_M,
    input  logic [31:0]       PCPlus4M,
    input  logic [31:0]       WriteDataM,
    input  logic [31:0]       ALU_ResultM,
    output logic              StallM,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [31:0]       dmem_req_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [31:0]       dmem_rsp_rdata,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [4:0]        RD_W,
    output logic [31:0]       PCPlus4W,
    output logic [31:0]       ALU_ResultW,
    output logic [31:0]       ReadDataW,
    output logic [1:0]        ExcW
);
    logic memop;
    logic aligned;
    logic misaligned;
    logic is_load;
    logic start;
    logic stall;
    logic done;
    logic abort;

    logic        reg_write_p1;
    logic [1:0]  result_src_p1;
    logic [4:0]  rd_p1;
    logic [31:0] pc_plus4_p1;
    logic [31:0] alu_result_p1;
    logic [31:0] read_data_p1;
    logic [1:0]  exc_p1;

    assign memop      = MemWriteM | (ResultSrcM == RES_MEM);
    assign aligned    = (ALU_ResultM[1:0] == 2'b00);
    assign start      = memop & aligned;
    assign misaligned = memop & ~aligned;
    assign is_load    = ~MemWriteM & (ResultSrcM == RES_MEM);

    mem_access_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .req_ready(dmem_req_ready),
        .rsp_valid(dmem_rsp_valid),
        .req_valid(dmem_req_valid),
        .stall    (stall),
        .done     (done),
        .abort    (abort)
    );

    // Upstream holds the M inputs while stalled, so the payload is stable until the handshake.
    assign StallM         = stall;
    assign dmem_req_we    = MemWriteM;
    assign dmem_req_addr  = ALU_ResultM[ADDR_W-1:0];
    assign dmem_req_wdata = WriteDataM;

    // ---- M -> W pipeline register ----
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            reg_write_p1  <= 1'b0;
            result_src_p1 <= 2'b00;
            rd_p1         <= 5'd0;
            pc_plus4_p1   <= 32'd0;
            alu_result_p1 <= 32'd0;
            read_data_p1  <= 32'd0;
            exc_p1        <= EXC_NONE;
        end else begin
            reg_write_p1  <= RegWriteM & ~misaligned & ~abort;
            result_src_p1 <= ResultSrcM;
            rd_p1         <= RD_M;
            pc_plus4_p1   <= PCPlus4M;
            alu_result_p1 <= ALU_ResultM;
            read_data_p1  <= (done && is_load) ? dmem_rsp_rdata : 32'd0;
            exc_p1        <= misaligned ? EXC_MISALIGN : (abort ? EXC_TIMEOUT : EXC_NONE);
        end
    end

    assign RegWriteW   = reg_write_p1;
    assign ResultSrcW  = result_src_p1;
    assign RD_W        = rd_p1;
    assign PCPlus4W    = pc_plus4_p1;
    assign ALU_ResultW = alu_result_p1;
    assign ReadDataW   = read_data_p1;
    assign ExcW        = exc_p1;
endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: directed scenarios plus randomized back-to-back
// instructions against a transaction-level reference model with a responding memory.
module tb_memory_cycle;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteM = 1'b0, MemWriteM = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic [4:0]  RD_M = 5'd0;
    logic [31:0] PCPlus4M = 32'd0, WriteDataM = 32'd0, ALU_ResultM = 32'd0;
    logic        StallM, dmem_req_valid, dmem_req_we;
    logic        dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic [31:0] dmem_rsp_rdata = 32'd0;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW, ExcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    memory_cycle #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .StallM(StallM),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .ExcW(ExcW)
    );

    typedef struct {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] wd;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          rdy_dly;  // cycles the memory keeps ready low
        int          rsp_dly;  // cycles from handshake to response
        bit          stray;    // drive rsp_valid where the stage must ignore it
    } op_t;

    // Transaction-level outcome of one instruction: how long it occupies M, how long it
    // requests the bus, and what writeback finally sees.
    function automatic void model(input op_t o, output int cycles, output int req_cycles,
                                  output logic rw, output logic [31:0] rdata,
                                  output logic [1:0] exc);
        bit memop;
        memop = o.mw || (o.rs == 2'b01);
        cycles = 1; req_cycles = 0; rw = o.rw; rdata = 32'd0; exc = 2'b00;
        if (memop && o.addr[1:0] != 2'b00) begin
            rw = 1'b0; exc = 2'b01;
        end else if (memop) begin
            req_cycles = o.rdy_dly + 1;
            if (o.rsp_dly <= TO + 1) begin
                cycles = req_cycles + o.rsp_dly;
                rdata  = o.mw ? 32'd0 : o.rdata;
            end else begin
                cycles = req_cycles + TO + 1;
                rw = 1'b0; exc = 2'b10;
            end
        end
    endfunction

    // Called just after a rising edge; returns just after the edge that retires the op.
    task automatic run_op(input op_t o, input string name);
        int cyc, reqc;
        logic erw;
        logic [31:0] erd;
        logic [1:0] eexc;
        model(o, cyc, reqc, erw, erd, eexc);
        RegWriteM = o.rw; MemWriteM = o.mw; ResultSrcM = o.rs; RD_M = o.rd;
        PCPlus4M = o.pc4; WriteDataM = o.wd; ALU_ResultM = o.addr;
        for (int c = 0; c < cyc; c++) begin
            dmem_req_ready = (reqc > 0) && (c == o.rdy_dly);
            dmem_rsp_valid = ((reqc > 0) && (c == o.rdy_dly + o.rsp_dly)) ||
                             (o.stray && ((reqc > 0) ? (c <= o.rdy_dly) : (c == 0)));
            dmem_rsp_rdata = ((reqc > 0) && (c == o.rdy_dly + o.rsp_dly)) ? o.rdata : $urandom;
            @(negedge clk);
            tests++;
            if (StallM !== (c < cyc - 1)) begin
                fails++;
                $display("FAIL %s stall c=%0d: got %b want %b", name, c, StallM, (c < cyc - 1));
            end
            tests++;
            if (dmem_req_valid !== (c < reqc)) begin
                fails++;
                $display("FAIL %s req_valid c=%0d: got %b want %b", name, c, dmem_req_valid, (c < reqc));
            end
            if (c < reqc) begin
                tests++;
                if ({dmem_req_we, dmem_req_addr, dmem_req_wdata} !== {o.mw, o.addr, o.wd}) begin
                    fails++;
                    $display("FAIL %s req_payload c=%0d: got %b/%h/%h want %b/%h/%h", name, c,
                             dmem_req_we, dmem_req_addr, dmem_req_wdata, o.mw, o.addr, o.wd);
                end
            end
            if (c > 0) begin
                tests++;
                if ({RegWriteW, ExcW} !== 3'b000) begin
                    fails++;
                    $display("FAIL %s bubble c=%0d: got rw=%b exc=%b want rw=0 exc=00", name, c, RegWriteW, ExcW);
                end
            end
            @(posedge clk);
            #1;
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        tests++;
        if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, ExcW} !==
            {erw, o.rs, o.rd, o.pc4, o.addr, erd, eexc}) begin
            fails++;
            $display("FAIL %s writeback: got rw=%b rs=%b rd=%0d pc4=%h alu=%h rdata=%h exc=%b want rw=%b rs=%b rd=%0d pc4=%h alu=%h rdata=%h exc=%b",
                     name, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, ExcW,
                     erw, o.rs, o.rd, o.pc4, o.addr, erd, eexc);
        end
    endtask

    function automatic op_t mk(input logic rw, input logic mw, input logic [1:0] rs,
                               input logic [4:0] rd, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rdata,
                               input int rdy, input int rsp, input bit stray);
        op_t o;
        o.rw = rw; o.mw = mw; o.rs = rs; o.rd = rd; o.pc4 = $urandom;
        o.wd = wd; o.addr = addr; o.rdata = rdata;
        o.rdy_dly = rdy; o.rsp_dly = rsp; o.stray = stray;
        return o;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        RegWriteM = 1'b1; ResultSrcM = 2'b01; ALU_ResultM = 32'h40; RD_M = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, ExcW} !== '0) begin
            fails++;
            $display("FAIL reset_w: got rw=%b rd=%0d alu=%h exc=%b want all zero", RegWriteW, RD_W, ALU_ResultW, ExcW);
        end
        tests++;
        if ({StallM, dmem_req_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ctrl: got stall=%b valid=%b want 0 0", StallM, dmem_req_valid);
        end
        rst = 1'b0;
        RegWriteM = 1'b0; ResultSrcM = 2'b00; ALU_ResultM = 32'd0; RD_M = 5'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu();
        run_op(mk(1'b1, 1'b0, 2'b00, 5'd5, 32'h0000_1234, $urandom, 32'd0, 0, 1, 1'b0), "alu");
        run_op(mk(1'b1, 1'b0, 2'b10, 5'd6, 32'h0000_0102, $urandom, 32'd0, 0, 1, 1'b0), "pc4");
    endtask

    task automatic test_load();
        run_op(mk(1'b1, 1'b0, 2'b01, 5'd3, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 2, 1'b0), "load");
    endtask

    task automatic test_store();
        run_op(mk(1'b0, 1'b1, 2'b00, 5'd0, 32'h0000_0200, 32'hA5A5_A5A5, $urandom, 3, 1, 1'b0), "store");
    endtask

    task automatic test_misaligned();
        run_op(mk(1'b1, 1'b0, 2'b01, 5'd4, 32'h0000_0102, 32'd0, $urandom, 0, 1, 1'b0), "misalign");
    endtask

    task automatic test_timeout();
        run_op(mk(1'b1, 1'b0, 2'b01, 5'd8, 32'h0000_0300, 32'd0, $urandom, 0, 200, 1'b0), "timeout");
        run_op(mk(1'b1, 1'b0, 2'b00, 5'd9, $urandom, 32'd0, $urandom, 0, 1, 1'b1), "late_rsp");
        run_op(mk(1'b1, 1'b0, 2'b01, 5'd10, 32'h0000_0304, 32'd0, 32'h1357_9BDF, 1, TO + 1, 1'b1), "rsp_at_limit");
    endtask

    task automatic test_reset_mid();
        RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; RD_M = 5'd11;
        ALU_ResultM = 32'h0000_0400;
        dmem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        RegWriteM = 1'b1; ResultSrcM = 2'b00; RD_M = 5'd7; ALU_ResultM = 32'h0000_0055;
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hCAFE_F00D;
        tests++;
        if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, ExcW} !== '0) begin
            fails++;
            $display("FAIL rst_mid_w: got rw=%b rd=%0d rdata=%h exc=%b want all zero", RegWriteW, RD_W, ReadDataW, ExcW);
        end
        @(negedge clk);
        tests++;
        if ({StallM, dmem_req_valid} !== 2'b00) begin
            fails++;
            $display("FAIL rst_mid_ctrl: got stall=%b valid=%b want 0 0", StallM, dmem_req_valid);
        end
        @(posedge clk);
        #1;
        dmem_rsp_valid = 1'b0;
        tests++;
        if ({RegWriteW, RD_W, ReadDataW, ExcW} !== {1'b1, 5'd7, 32'd0, 2'b00}) begin
            fails++;
            $display("FAIL rst_mid_rsp: got rw=%b rd=%0d rdata=%h exc=%b want rw=1 rd=7 rdata=0 exc=00",
                     RegWriteW, RD_W, ReadDataW, ExcW);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            op_t o;
            logic [1:0] rs;
            logic [31:0] addr;
            rs = 2'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            o = mk(1'($urandom), ($urandom_range(0, 2) == 0), rs, 5'($urandom), addr,
                   $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, TO + 3),
                   ($urandom_range(0, 2) == 0));
            run_op(o, "random");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
